// File: rtl/alu_share_if.sv
// Bundles the two request ports, the response port and the ALU-side connection of
// alu_share_arbiter. slave = arbiter side; master = requesters, consumer and ALU.
interface alu_share_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_op1;
  logic [DATA_WIDTH-1:0] req0_op2;
  logic [2:0]            req0_ctrl;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_op1;
  logic [DATA_WIDTH-1:0] req1_op2;
  logic [2:0]            req1_ctrl;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_sum;
  logic                  rsp_eq;
  logic                  rsp_err;

  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic [2:0]            alu_ctrl;
  logic [DATA_WIDTH-1:0] alu_sum;
  logic                  alu_eq;

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_ctrl,
    input  req1_valid, req1_op1, req1_op2, req1_ctrl,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_eq, rsp_err,
    input  rsp_ready,
    output alu_op1, alu_op2, alu_ctrl,
    input  alu_sum, alu_eq
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_ctrl,
    output req1_valid, req1_op1, req1_op2, req1_ctrl,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_eq, rsp_err,
    output rsp_ready,
    input  alu_op1, alu_op2, alu_ctrl,
    output alu_sum, alu_eq
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external ALU between two requesters: accept, drive the
// ALU from registered operands for one cycle, then hold the result until consumed.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_share_if.slave bus
);
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [2:0]            ctrl;
  } req_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state, state_nxt;
  logic [NUM_REQ-1:0]      req_vld;
  logic [NUM_REQ-1:0]      req_rdy;
  req_t [NUM_REQ-1:0]      req_pld;
  logic                    gnt;
  logic                    accept;
  logic                    prio;

  logic [DATA_WIDTH-1:0]   op1_q, op2_q;
  logic [2:0]              ctrl_q;
  logic                    id_q, err_q;

  logic                    rsp_valid_q, rsp_id_q, rsp_eq_q, rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_sum_q;

  always_comb begin
    req_vld         = {bus.req1_valid, bus.req0_valid};
    req_pld[0].op1  = bus.req0_op1;
    req_pld[0].op2  = bus.req0_op2;
    req_pld[0].ctrl = bus.req0_ctrl;
    req_pld[1].op1  = bus.req1_op1;
    req_pld[1].op2  = bus.req1_op2;
    req_pld[1].ctrl = bus.req1_ctrl;
  end

  // Grant only in IDLE; on contention the priority pointer decides.
  always_comb begin
    state_nxt = state;
    gnt       = prio;
    accept    = 1'b0;
    req_rdy   = '0;
    case (state)
      IDLE: begin
        if (|req_vld) begin
          accept       = 1'b1;
          gnt          = (&req_vld) ? prio : req_vld[1];
          req_rdy[gnt] = 1'b1;
          state_nxt    = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      op1_q  <= '0;
      op2_q  <= '0;
      ctrl_q <= '0;
      id_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op1_q  <= req_pld[gnt].op1;
        op2_q  <= req_pld[gnt].op2;
        // Illegal ops still run through the ALU, but as a harmless add.
        ctrl_q <= req_pld[gnt].ctrl[2] ? 3'b000 : req_pld[gnt].ctrl;
        err_q  <= req_pld[gnt].ctrl[2];
        id_q   <= gnt;
        prio   <= ~gnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_eq_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= id_q;
      rsp_err_q   <= err_q;
      rsp_sum_q   <= err_q ? '0 : bus.alu_sum;
      rsp_eq_q    <= ~err_q & bus.alu_eq;
    end else if (state == RESP && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req0_ready = req_rdy[0];
  assign bus.req1_ready = req_rdy[1];

  assign bus.alu_op1  = op1_q;
  assign bus.alu_op2  = op2_q;
  assign bus.alu_ctrl = ctrl_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_eq    = rsp_eq_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_id;

  always #5 clk = ~clk;

  alu_share_if #(.DATA_WIDTH(32)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb begin
    bus.alu_sum = '0;
    case (bus.alu_ctrl)
      3'b000:  bus.alu_sum = bus.alu_op1 + bus.alu_op2;
      3'b001:  bus.alu_sum = bus.alu_op1 - bus.alu_op2;
      3'b010:  bus.alu_sum = bus.alu_op1 & bus.alu_op2;
      3'b011:  bus.alu_sum = bus.alu_op1 | bus.alu_op2;
      default: bus.alu_sum = '0;
    endcase
    bus.alu_eq = (bus.alu_op1 == bus.alu_op2);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    bus.req0_valid = v; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_ctrl = c;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    bus.req1_valid = v; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_ctrl = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    set_req0(1'b0, 0, 0, 3'b000);
    set_req1(1'b0, 0, 0, 3'b000);
    bus.rsp_ready = 1'b0;
    #1;
    do_reset();

    // reset state
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_sum",   bus.rsp_sum,   0);
    chk("rst_rsp_id",    bus.rsp_id,    0);
    chk("rst_rsp_eq_err", {bus.rsp_eq, bus.rsp_err}, 0);
    chk("rst_alu_op1",   bus.alu_op1,   0);
    chk("rst_alu_op2",   bus.alu_op2,   0);
    chk("rst_alu_ctrl",  bus.alu_ctrl,  0);
    chk("rst_ready",     {bus.req1_ready, bus.req0_ready}, 0);

    // 1: single add 5+7
    set_req0(1'b1, 5, 7, 3'b000);
    #1;
    chk("t1_req0_ready", bus.req0_ready, 1);
    chk("t1_req1_ready", bus.req1_ready, 0);
    step();
    bus.req0_valid = 1'b0;
    chk("t1_exec_valid", bus.rsp_valid, 0);
    chk("t1_exec_ready", bus.req0_ready, 0);
    chk("t1_alu_op1",    bus.alu_op1, 5);
    chk("t1_alu_op2",    bus.alu_op2, 7);
    chk("t1_alu_ctrl",   bus.alu_ctrl, 0);
    step();
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_sum",   bus.rsp_sum, 12);
    chk("t1_rsp_id",    bus.rsp_id, 0);
    chk("t1_rsp_eq",    bus.rsp_eq, 0);
    chk("t1_rsp_err",   bus.rsp_err, 0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("t1_rsp_drop", bus.rsp_valid, 0);

    // 2: both valid from reset, req0 wins first
    do_reset();
    set_req0(1'b1, 9, 9, 3'b001);
    set_req1(1'b1, 32'hF0, 32'h0F, 3'b011);
    bus.rsp_ready = 1'b1;
    #1;
    chk("t2_gnt0_r0", bus.req0_ready, 1);
    chk("t2_gnt0_r1", bus.req1_ready, 0);
    step();
    bus.req0_valid = 1'b0;
    step();
    chk("t2_rsp0_valid", bus.rsp_valid, 1);
    chk("t2_rsp0_sum",   bus.rsp_sum, 0);
    chk("t2_rsp0_eq",    bus.rsp_eq, 1);
    chk("t2_rsp0_id",    bus.rsp_id, 0);
    step();
    #1;
    chk("t2_gnt1_r1", bus.req1_ready, 1);
    step();
    bus.req1_valid = 1'b0;
    step();
    chk("t2_rsp1_sum", bus.rsp_sum, 32'hFF);
    chk("t2_rsp1_id",  bus.rsp_id, 1);
    chk("t2_rsp1_eq",  bus.rsp_eq, 0);
    step();

    // 3: both held valid, grants alternate
    set_req0(1'b1, 3, 4, 3'b000);
    set_req1(1'b1, 32'hC, 32'hA, 3'b010);
    for (int k = 0; k < 4; k++) begin
      exp_id = k % 2;
      #1;
      chk("t3_req0_ready", bus.req0_ready, (exp_id == 0));
      chk("t3_req1_ready", bus.req1_ready, (exp_id == 1));
      step();
      step();
      chk("t3_rsp_id",  bus.rsp_id, exp_id);
      chk("t3_rsp_sum", bus.rsp_sum, (exp_id == 0) ? 7 : 8);
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;

    // 4: consumer stalls for 10 cycles
    set_req0(1'b1, 1, 2, 3'b000);
    #1;
    step();
    bus.req0_valid = 1'b0;
    set_req1(1'b1, 32'h11, 32'h11, 3'b101);
    step();
    for (int k = 0; k < 10; k++) begin
      chk("t4_stall_valid", bus.rsp_valid, 1);
      chk("t4_stall_sum",   bus.rsp_sum, 3);
      chk("t4_stall_id",    bus.rsp_id, 0);
      chk("t4_stall_ready", {bus.req1_ready, bus.req0_ready}, 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("t4_rel_valid", bus.rsp_valid, 0);
    chk("t4_idle_r1",   bus.req1_ready, 1);

    // 5: illegal ctrl from req1, then wrapping add
    step();
    bus.req1_valid = 1'b0;
    chk("t5_alu_ctrl", bus.alu_ctrl, 0);
    step();
    chk("t5_err", bus.rsp_err, 1);
    chk("t5_sum", bus.rsp_sum, 0);
    chk("t5_eq",  bus.rsp_eq, 0);
    chk("t5_id",  bus.rsp_id, 1);
    bus.rsp_ready = 1'b1;
    step();
    set_req0(1'b1, 32'hFFFF_FFFF, 32'h1, 3'b000);
    #1;
    step();
    bus.req0_valid = 1'b0;
    step();
    chk("t5_wrap_valid", bus.rsp_valid, 1);
    chk("t5_wrap_sum",   bus.rsp_sum, 0);
    chk("t5_wrap_err",   bus.rsp_err, 0);
    chk("t5_wrap_eq",    bus.rsp_eq, 0);
    step();

    // 6: reset during EXEC
    set_req0(1'b1, 5, 6, 3'b000);
    #1;
    step();
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus.rsp_valid, 0);
    chk("t6_rst_op1",   bus.alu_op1, 0);
    chk("t6_rst_op2",   bus.alu_op2, 0);
    chk("t6_rst_ctrl",  bus.alu_ctrl, 0);
    step();
    chk("t6_rst_valid2", bus.rsp_valid, 0);
    rst = 1'b0;
    set_req0(1'b1, 1, 1, 3'b000);
    set_req1(1'b1, 32'hF0, 32'h3C, 3'b010);
    #1;
    chk("t6_prio_r0", bus.req0_ready, 1);
    chk("t6_prio_r1", bus.req1_ready, 0);
    bus.req0_valid = 1'b0;
    #1;
    chk("t6_r1_ready", bus.req1_ready, 1);
    step();
    bus.req1_valid = 1'b0;
    step();
    chk("t6_rsp_valid", bus.rsp_valid, 1);
    chk("t6_rsp_id",    bus.rsp_id, 1);
    chk("t6_rsp_sum",   bus.rsp_sum, 32'h30);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
